// File: rtl/pool_seq_mc.sv
// Multi-channel sequential 1-D pooling (max or average) over a channel-interleaved stream.
// One registered result per channel per non-overlapping window of N time steps.
module pool_seq_mc #(
  parameter int BIT_WIDTH = 12,
  parameter int N         = 3,
  parameter int C         = 4,
  parameter int MODE      = 0,
  parameter int SIGNED    = 0,
  parameter int POOL_INIT = 0,
  localparam int CW       = (C > 1) ? $clog2(C) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 in_valid,
  input  logic [BIT_WIDTH-1:0] data_in,
  output logic                 out_valid,
  output logic [BIT_WIDTH-1:0] data_out,
  output logic [CW-1:0]        out_ch
);

  localparam int LOGN  = (N > 1) ? $clog2(N) : 0;
  localparam int PW    = (N > 1) ? $clog2(N) : 1;
  localparam int ACC_W = (MODE == 1) ? BIT_WIDTH + LOGN : BIT_WIDTH;

  generate
    if (N < 1 || N > 16) begin : g_bad_n
      $error("pool_seq_mc: N must be 1..16");
    end
    if (C < 1 || C > 64) begin : g_bad_c
      $error("pool_seq_mc: C must be 1..64");
    end
    if (MODE == 1 && (N & (N - 1)) != 0) begin : g_bad_avg
      $error("pool_seq_mc: average mode needs N to be a power of two");
    end
    if (POOL_INIT < 0 || POOL_INIT >= N) begin : g_bad_init
      $error("pool_seq_mc: POOL_INIT must be 0..N-1");
    end
  endgenerate

  logic [CW-1:0]        ch_cnt;
  logic [PW-1:0]        pos_cnt;
  logic [ACC_W-1:0]     acc [C];
  logic [C-1:0]         acc_vld;

  logic [ACC_W-1:0]        acc_cur, samp_u, samp_ext, acc_nxt;
  logic signed [ACC_W-1:0] samp_s, acc_nxt_s;
  logic [BIT_WIDTH-1:0]    res_u, res_s, data_nxt;
  logic                    samp_gt, seed, last_pos, last_ch;

  always_comb begin
    acc_cur  = acc[ch_cnt];
    samp_s   = ACC_W'($signed(data_in));
    samp_u   = ACC_W'(data_in);
    samp_ext = (SIGNED == 1) ? samp_s : samp_u;
    samp_gt  = (SIGNED == 1) ? ($signed(samp_ext) > $signed(acc_cur)) : (samp_ext > acc_cur);
    // An entry never seen since reset/clear is seeded too, so a POOL_INIT-shortened window is clean.
    seed     = (pos_cnt == '0) || !acc_vld[ch_cnt];
    last_pos = (pos_cnt == PW'(N - 1));
    last_ch  = (ch_cnt == CW'(C - 1));

    if (seed)
      acc_nxt = samp_ext;
    else if (MODE == 0)
      acc_nxt = samp_gt ? samp_ext : acc_cur;
    else
      acc_nxt = acc_cur + samp_ext;

    acc_nxt_s = acc_nxt;
    res_s     = BIT_WIDTH'(acc_nxt_s >>> LOGN);
    res_u     = BIT_WIDTH'(acc_nxt >> LOGN);
    if (MODE == 1)
      data_nxt = (SIGNED == 1) ? res_s : res_u;
    else
      data_nxt = BIT_WIDTH'(acc_nxt);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_cnt    <= '0;
      pos_cnt   <= PW'(POOL_INIT);
      acc_vld   <= '0;
      out_valid <= 1'b0;
      data_out  <= '0;
      out_ch    <= '0;
      for (int i = 0; i < C; i++) acc[i] <= '0;
    end else if (clear) begin
      ch_cnt    <= '0;
      pos_cnt   <= PW'(POOL_INIT);
      acc_vld   <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (in_valid) begin
        acc[ch_cnt]     <= acc_nxt;
        acc_vld[ch_cnt] <= 1'b1;
        if (last_pos) begin
          out_valid <= 1'b1;
          out_ch    <= ch_cnt;
          data_out  <= data_nxt;
        end
        if (last_ch) begin
          ch_cnt  <= '0;
          pos_cnt <= last_pos ? '0 : pos_cnt + 1'b1;
        end else begin
          ch_cnt <= ch_cnt + 1'b1;
        end
      end
    end
  end

endmodule
